// File: rtl/jm_kernel_adapter_if.sv
// jm_kernel_adapter_if
// Groups the signals between the job-manager framework, the adapter and the
// HLS kernels (ap_ctrl_hs) into one bundle.
//   slave  : adapter side (takes engine_start/jd_payload/ap_* from outside,
//            drives engine_done/return_code/ap_start/payload/status)
//   master : environment side (job manager + kernels), the mirror of slave
// Signal names keep the adapter's port view (_i = into adapter, _o = out of it).
interface jm_kernel_adapter_if #(
    parameter int KERNEL_NUM  = 2,
    parameter int HOST_DWIDTH = 1024,
    parameter int RET_WIDTH   = 32,
    parameter int TMO_WIDTH   = 32
);
    logic [KERNEL_NUM-1:0]             engine_start_i;
    logic [HOST_DWIDTH-1:0]            jd_payload_i;
    logic [KERNEL_NUM-1:0]             engine_done_o;
    logic [RET_WIDTH-1:0]              return_code_o;
    logic [KERNEL_NUM-1:0]             ap_start_o;
    logic [KERNEL_NUM-1:0]             ap_ready_i;
    logic [KERNEL_NUM-1:0]             ap_done_i;
    logic [KERNEL_NUM*RET_WIDTH-1:0]   ap_return_i;
    logic [KERNEL_NUM*HOST_DWIDTH-1:0] kernel_payload_o;
    logic [TMO_WIDTH-1:0]              tmo_cycles_i;
    logic [KERNEL_NUM-1:0]             start_err_o;
    logic [KERNEL_NUM-1:0]             tmo_flag_o;

    modport slave (
        input  engine_start_i, jd_payload_i, ap_ready_i, ap_done_i,
               ap_return_i, tmo_cycles_i,
        output engine_done_o, return_code_o, ap_start_o, kernel_payload_o,
               start_err_o, tmo_flag_o
    );

    modport master (
        output engine_start_i, jd_payload_i, ap_ready_i, ap_done_i,
               ap_return_i, tmo_cycles_i,
        input  engine_done_o, return_code_o, ap_start_o, kernel_payload_o,
               start_err_o, tmo_flag_o
    );
endinterface

// File: rtl/jm_kernel_adapter.sv
// jm_kernel_adapter
// Bridges the job-manager per-kernel start/done interface to KERNEL_NUM
// ap_ctrl_hs kernels. Each kernel has its own FSM that latches the job
// payload, runs the ap_start/ap_ready handshake and captures ap_return on
// ap_done. Finished kernels are serialized by a round-robin arbiter onto a
// single registered engine_done/return_code output.
// Ports:
//   clk     : single clock
//   resetn  : synchronous active-low reset
//   bus     : jm_kernel_adapter_if.slave (job-manager and kernel signals)
// Optional feature: define JM_ADAPTER_TIMEOUT_EN for a per-kernel watchdog
// (tmo_cycles_i, 0 disables) that forces an all-ones return code.
//
// Per-kernel FSM:
//   state    | meaning
//   S_IDLE   | waiting for engine_start
//   S_START  | ap_start high, waiting for ap_ready
//   S_RUN    | kernel accepted, waiting for ap_done
//   S_REPORT | result captured, waiting for / presenting the arbiter grant
module jm_kernel_adapter #(
    parameter int KERNEL_NUM  = 2,
    parameter int HOST_DWIDTH = 1024,
    parameter int RET_WIDTH   = 32,
    parameter int TMO_WIDTH   = 32
) (
    input  logic               clk,
    input  logic               resetn,
    jm_kernel_adapter_if.slave bus
);
    localparam int PW = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_REPORT = 2'd3
    } state_e;

    state_e state_q [KERNEL_NUM];
    state_e state_d [KERNEL_NUM];

    logic [KERNEL_NUM-1:0][HOST_DWIDTH-1:0] payload_q;
    logic [KERNEL_NUM-1:0][RET_WIDTH-1:0]   ret_q;
    logic [KERNEL_NUM-1:0]                  done_q, done_d;
    logic [RET_WIDTH-1:0]                   ret_out_q, ret_out_d;
    logic [PW-1:0]                          rr_ptr_q, rr_ptr_d;
    logic [KERNEL_NUM-1:0]                  start_err_q;

    logic [KERNEL_NUM-1:0] ld_payload;
    logic [KERNEL_NUM-1:0] cap_ret;
    logic [KERNEL_NUM-1:0] cap_tmo;
    logic [KERNEL_NUM-1:0] err_set;
    logic [KERNEL_NUM-1:0] tmo_hit;
    logic [KERNEL_NUM-1:0] req;
    logic [KERNEL_NUM-1:0] ap_start;
    logic                  grant_vld;
    logic [PW-1:0]         grant_idx;

    // Per-kernel next-state logic
    always_comb begin
        for (int k = 0; k < KERNEL_NUM; k++) begin
            state_d[k]    = state_q[k];
            ld_payload[k] = 1'b0;
            cap_ret[k]    = 1'b0;
            cap_tmo[k]    = 1'b0;
            err_set[k]    = 1'b0;
            ap_start[k]   = (state_q[k] == S_START);
            req[k]        = (state_q[k] == S_REPORT) && !done_q[k];

            unique case (state_q[k])
                S_IDLE: begin
                    if (bus.engine_start_i[k]) begin
                        ld_payload[k] = 1'b1;
                        state_d[k]    = S_START;
                    end
                end
                S_START: begin
                    // A real completion on the same edge wins over the watchdog.
                    if (bus.ap_ready_i[k]) begin
                        if (bus.ap_done_i[k]) begin
                            cap_ret[k] = 1'b1;
                            state_d[k] = S_REPORT;
                        end else begin
                            state_d[k] = S_RUN;
                        end
                    end else if (tmo_hit[k]) begin
                        cap_tmo[k] = 1'b1;
                        state_d[k] = S_REPORT;
                    end
                end
                S_RUN: begin
                    if (bus.ap_done_i[k]) begin
                        cap_ret[k] = 1'b1;
                        state_d[k] = S_REPORT;
                    end else if (tmo_hit[k]) begin
                        cap_tmo[k] = 1'b1;
                        state_d[k] = S_REPORT;
                    end
                end
                S_REPORT: begin
                    // done_q set means this cycle is the presented pulse.
                    if (done_q[k]) begin
                        state_d[k] = S_IDLE;
                    end
                end
                default: state_d[k] = S_IDLE;
            endcase

            if (bus.engine_start_i[k] && (state_q[k] != S_IDLE)) begin
                err_set[k] = 1'b1;
            end
        end
    end

    // Round-robin arbiter: search from rr_ptr_q, first requester wins.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_p;
        idx       = 0;
        idx_p     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < KERNEL_NUM; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= KERNEL_NUM) begin
                idx = idx - KERNEL_NUM;
            end
            idx_p = PW'(idx);
            if (!grant_vld && req[idx_p]) begin
                grant_vld = 1'b1;
                grant_idx = idx_p;
            end
        end

        done_d    = '0;
        ret_out_d = '0;
        rr_ptr_d  = rr_ptr_q;
        if (grant_vld) begin
            done_d    = KERNEL_NUM'(1) << grant_idx;
            ret_out_d = ret_q[grant_idx];
            if (int'(grant_idx) == KERNEL_NUM - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < KERNEL_NUM; k++) begin
                state_q[k] <= S_IDLE;
            end
            payload_q   <= '0;
            ret_q       <= '0;
            done_q      <= '0;
            ret_out_q   <= '0;
            rr_ptr_q    <= '0;
            start_err_q <= '0;
        end else begin
            for (int k = 0; k < KERNEL_NUM; k++) begin
                state_q[k] <= state_d[k];
                if (ld_payload[k]) begin
                    payload_q[k] <= bus.jd_payload_i;
                end
                if (cap_ret[k]) begin
                    ret_q[k] <= bus.ap_return_i[k*RET_WIDTH +: RET_WIDTH];
                end else if (cap_tmo[k]) begin
                    ret_q[k] <= '1;
                end
            end
            done_q      <= done_d;
            ret_out_q   <= ret_out_d;
            rr_ptr_q    <= rr_ptr_d;
            start_err_q <= start_err_q | err_set;
        end
    end

`ifdef JM_ADAPTER_TIMEOUT_EN
    logic [KERNEL_NUM-1:0][TMO_WIDTH-1:0] cnt_q;
    logic [KERNEL_NUM-1:0]                tmo_flag_q;

    always_comb begin
        for (int k = 0; k < KERNEL_NUM; k++) begin
            tmo_hit[k] = (bus.tmo_cycles_i != '0) &&
                         (cnt_q[k] == bus.tmo_cycles_i - TMO_WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q      <= '0;
            tmo_flag_q <= '0;
        end else begin
            for (int k = 0; k < KERNEL_NUM; k++) begin
                if ((state_q[k] == S_IDLE) && (state_d[k] == S_START)) begin
                    cnt_q[k] <= '0;
                end else if ((state_q[k] == S_START) || (state_q[k] == S_RUN)) begin
                    cnt_q[k] <= cnt_q[k] + TMO_WIDTH'(1);
                end
            end
            tmo_flag_q <= tmo_flag_q | cap_tmo;
        end
    end

    assign bus.tmo_flag_o = tmo_flag_q;
`else
    logic unused_tmo;
    assign unused_tmo     = ^bus.tmo_cycles_i;
    assign tmo_hit        = '0;
    assign bus.tmo_flag_o = '0;
`endif

    assign bus.ap_start_o       = ap_start;
    assign bus.kernel_payload_o = payload_q;
    assign bus.engine_done_o    = done_q;
    assign bus.return_code_o    = ret_out_q;
    assign bus.start_err_o      = start_err_q;

endmodule

// File: tb/tb_jm_kernel_adapter.sv
// tb_jm_kernel_adapter
// Table-driven bench for jm_kernel_adapter (KERNEL_NUM=2, defaults).
// Each table row drives one clock's worth of inputs and lists the expected
// registered outputs after that edge. Hand-written sequences cover reset
// mid-job and, when JM_ADAPTER_TIMEOUT_EN is defined, the watchdog.
module tb_jm_kernel_adapter;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    jm_kernel_adapter_if #(.KERNEL_NUM(2), .HOST_DWIDTH(1024), .RET_WIDTH(32), .TMO_WIDTH(32)) bif ();

    jm_kernel_adapter #(.KERNEL_NUM(2), .HOST_DWIDTH(1024), .RET_WIDTH(32), .TMO_WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif.slave)
    );

    typedef struct {
        logic [1:0]  start;
        logic [7:0]  pl;
        logic [1:0]  rdy;
        logic [1:0]  dn;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [1:0]  es;
        logic [1:0]  ed;
        logic [31:0] eret;
        logic [1:0]  eerr;
        logic [7:0]  ep0;
        logic [7:0]  ep1;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] start, input logic [7:0] pl, input logic [1:0] rdy,
                       input logic [1:0] dn, input logic [31:0] r0, input logic [31:0] r1,
                       input logic [1:0] es, input logic [1:0] ed, input logic [31:0] eret,
                       input logic [1:0] eerr, input logic [7:0] ep0, input logic [7:0] ep1);
        vec_t v;
        v.start = start; v.pl = pl; v.rdy = rdy; v.dn = dn; v.r0 = r0; v.r1 = r1;
        v.es = es; v.ed = ed; v.eret = eret; v.eerr = eerr; v.ep0 = ep0; v.ep1 = ep1;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        bif.engine_start_i = '0;
        bif.jd_payload_i   = '0;
        bif.ap_ready_i     = '0;
        bif.ap_done_i      = '0;
        bif.ap_return_i    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1023:0] rep(input logic [7:0] b);
        return {128{b}};
    endfunction

    initial begin
        bit got;
        int n;

        // start pl rdy dn r0 r1 | es ed eret eerr ep0 ep1
        // kernel 0 alone: ready 2 cycles after start, done later with 0x1234
        add(2'b01, 8'hA5, 2'b00, 2'b00, 0, 0,  2'b01, 2'b00, 0, 2'b00, 8'hA5, 8'h00);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b01, 2'b00, 0, 2'b00, 8'hA5, 8'h00);
        add(2'b00, 8'h00, 2'b01, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b00, 8'hA5, 8'h00);
        for (int i = 0; i < 9; i++)
            add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 8'hA5, 8'h00);
        add(2'b00, 8'h00, 2'b00, 2'b01, 32'h1234, 0, 2'b00, 2'b00, 0, 2'b00, 8'hA5, 8'h00);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b01, 32'h1234, 2'b00, 8'hA5, 8'h00);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b00, 8'hA5, 8'h00);
        // simultaneous dones, pointer now 1 -> kernel 1 first
        add(2'b11, 8'h3C, 2'b00, 2'b00, 0, 0,  2'b11, 2'b00, 0, 2'b00, 8'h3C, 8'h3C);
        add(2'b00, 8'h00, 2'b11, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b00, 8'h3C, 8'h3C);
        add(2'b00, 8'h00, 2'b00, 2'b11, 32'h11, 32'h22, 2'b00, 2'b00, 0, 2'b00, 8'h3C, 8'h3C);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b10, 32'h22, 2'b00, 8'h3C, 8'h3C);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b01, 32'h11, 2'b00, 8'h3C, 8'h3C);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b00, 8'h3C, 8'h3C);
        // kernel 1 alone with a second start during RUN (ignored, flagged)
        add(2'b10, 8'h5A, 2'b00, 2'b00, 0, 0,  2'b10, 2'b00, 0, 2'b00, 8'h3C, 8'h5A);
        add(2'b00, 8'h00, 2'b10, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b00, 8'h3C, 8'h5A);
        add(2'b10, 8'hFF, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b10, 8'h3C, 8'h5A);
        add(2'b00, 8'h00, 2'b00, 2'b10, 0, 32'h33, 2'b00, 2'b00, 0, 2'b10, 8'h3C, 8'h5A);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b10, 32'h33, 2'b10, 8'h3C, 8'h5A);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b10, 8'h3C, 8'h5A);
        // simultaneous dones, pointer now 0 -> kernel 0 first
        add(2'b11, 8'h77, 2'b00, 2'b00, 0, 0,  2'b11, 2'b00, 0, 2'b10, 8'h77, 8'h77);
        add(2'b00, 8'h00, 2'b11, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b10, 8'h77, 8'h77);
        add(2'b00, 8'h00, 2'b00, 2'b11, 32'h11, 32'h22, 2'b00, 2'b00, 0, 2'b10, 8'h77, 8'h77);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b01, 32'h11, 2'b10, 8'h77, 8'h77);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b10, 32'h22, 2'b10, 8'h77, 8'h77);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b10, 8'h77, 8'h77);
        // ready+done on the same edge; start during the done pulse is ignored
        add(2'b01, 8'hC3, 2'b00, 2'b00, 0, 0,  2'b01, 2'b00, 0, 2'b10, 8'hC3, 8'h77);
        add(2'b00, 8'h00, 2'b01, 2'b01, 32'h7, 0, 2'b00, 2'b00, 0, 2'b10, 8'hC3, 8'h77);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b01, 32'h7, 2'b10, 8'hC3, 8'h77);
        add(2'b01, 8'h99, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b11, 8'hC3, 8'h77);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b11, 8'hC3, 8'h77);
        // ap_done while idle is ignored
        add(2'b00, 8'h00, 2'b00, 2'b01, 32'hDEAD, 0, 2'b00, 2'b00, 0, 2'b11, 8'hC3, 8'h77);
        add(2'b00, 8'h00, 2'b00, 2'b00, 0, 0,  2'b00, 2'b00, 0, 2'b11, 8'hC3, 8'h77);

        idle_inputs();
        bif.tmo_cycles_i = '0;
        resetn = 1'b0;
        repeat (3) tick();
        chk("reset ap_start", bif.ap_start_o, 2'b00);
        chk("reset engine_done", bif.engine_done_o, 2'b00);
        chk("reset return_code", bif.return_code_o, 32'h0);
        chk("reset start_err", bif.start_err_o, 2'b00);
        chk("reset tmo_flag", bif.tmo_flag_o, 2'b00);
        chk("reset payload", bif.kernel_payload_o[1023:0], '0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bif.engine_start_i = vecs[i].start;
            bif.jd_payload_i   = rep(vecs[i].pl);
            bif.ap_ready_i     = vecs[i].rdy;
            bif.ap_done_i      = vecs[i].dn;
            bif.ap_return_i    = {vecs[i].r1, vecs[i].r0};
            tick();
            chk($sformatf("v%0d ap_start", i), bif.ap_start_o, vecs[i].es);
            chk($sformatf("v%0d engine_done", i), bif.engine_done_o, vecs[i].ed);
            if (vecs[i].ed != 2'b00)
                chk($sformatf("v%0d return_code", i), bif.return_code_o, vecs[i].eret);
            chk($sformatf("v%0d start_err", i), bif.start_err_o, vecs[i].eerr);
            chk($sformatf("v%0d payload0", i), bif.kernel_payload_o[1023:0], rep(vecs[i].ep0));
            chk($sformatf("v%0d payload1", i), bif.kernel_payload_o[2047:1024], rep(vecs[i].ep1));
        end

        // Reset with kernel 0 in RUN and kernel 1 in START
        @(negedge clk);
        idle_inputs();
        bif.engine_start_i = 2'b11;
        bif.jd_payload_i   = rep(8'hAB);
        tick();
        @(negedge clk);
        idle_inputs();
        bif.ap_ready_i = 2'b01;
        tick();
        chk("pre-reset ap_start", bif.ap_start_o, 2'b10);
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        tick();
        chk("midreset ap_start", bif.ap_start_o, 2'b00);
        chk("midreset start_err", bif.start_err_o, 2'b00);
        chk("midreset payload0", bif.kernel_payload_o[1023:0], '0);
        chk("midreset engine_done", bif.engine_done_o, 2'b00);
        @(negedge clk);
        resetn = 1'b1;
        bif.ap_done_i   = 2'b01;
        bif.ap_return_i = {32'h0, 32'h55};
        tick();
        @(negedge clk);
        idle_inputs();
        got = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bif.engine_done_o != 2'b00) got = 1'b1;
        end
        chk("postreset stray done", got, 1'b0);

        // Fresh job after reset completes normally
        @(negedge clk);
        bif.engine_start_i = 2'b01;
        bif.jd_payload_i   = rep(8'h42);
        tick();
        @(negedge clk);
        idle_inputs();
        bif.ap_ready_i = 2'b01;
        tick();
        @(negedge clk);
        idle_inputs();
        bif.ap_done_i   = 2'b01;
        bif.ap_return_i = {32'h0, 32'h99};
        tick();
        @(negedge clk);
        idle_inputs();
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bif.engine_done_o != 2'b00) got = 1'b1;
        end
        chk("recover done seen", got, 1'b1);
        chk("recover engine_done", bif.engine_done_o, 2'b01);
        chk("recover return_code", bif.return_code_o, 32'h99);
        chk("recover payload0", bif.kernel_payload_o[1023:0], rep(8'h42));

`ifdef JM_ADAPTER_TIMEOUT_EN
        // Watchdog: 20-cycle limit, kernel 0 never finishes
        repeat (3) tick();
        @(negedge clk);
        bif.tmo_cycles_i   = 32'd20;
        bif.engine_start_i = 2'b01;
        bif.jd_payload_i   = rep(8'h10);
        tick();
        @(negedge clk);
        idle_inputs();
        bif.ap_ready_i = 2'b01;
        tick();
        @(negedge clk);
        idle_inputs();
        n   = 1;
        got = 1'b0;
        while (n < 60 && !got) begin
            tick();
            n++;
            if (bif.engine_done_o != 2'b00) got = 1'b1;
        end
        chk("tmo done seen", got, 1'b1);
        chk("tmo done cycle", n, 21);
        chk("tmo engine_done", bif.engine_done_o, 2'b01);
        chk("tmo return_code", bif.return_code_o, 32'hFFFF_FFFF);
        chk("tmo flag", bif.tmo_flag_o, 2'b01);
        chk("tmo ap_start", bif.ap_start_o, 2'b00);
        @(negedge clk);
        bif.ap_done_i   = 2'b01;
        bif.ap_return_i = {32'h0, 32'h5};
        tick();
        @(negedge clk);
        idle_inputs();
        got = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bif.engine_done_o != 2'b00) got = 1'b1;
        end
        chk("tmo late done ignored", got, 1'b0);

        // Watchdog disabled: kernel 1 runs long without timing out
        @(negedge clk);
        bif.tmo_cycles_i   = '0;
        bif.engine_start_i = 2'b10;
        bif.jd_payload_i   = rep(8'h20);
        tick();
        @(negedge clk);
        idle_inputs();
        bif.ap_ready_i = 2'b10;
        tick();
        @(negedge clk);
        idle_inputs();
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bif.engine_done_o != 2'b00) got = 1'b1;
        end
        chk("notmo no early done", got, 1'b0);
        @(negedge clk);
        bif.ap_done_i   = 2'b10;
        bif.ap_return_i = {32'h66, 32'h0};
        tick();
        @(negedge clk);
        idle_inputs();
        tick();
        chk("notmo engine_done", bif.engine_done_o, 2'b10);
        chk("notmo return_code", bif.return_code_o, 32'h66);
        chk("notmo flag", bif.tmo_flag_o, 2'b01);
`else
        n = 0;
        repeat (3) tick();
        chk("tmo_flag tied low", bif.tmo_flag_o, 2'b00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
